idma_xfer_tracker: RTL and testbench

//  Downstream of the iDMA controller: consumes its start/done/error/direction strobes and tracks in-flight transfers.

---
 rtl/idma_xfer_tracker.sv | 197 +++++++++++++++++++
 tb/tb_idma_xfer_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/idma_xfer_tracker.sv
// In-flight transfer tracker for the iDMA controller: wrapping IDs, in-order FIFO, wait/evt/err.
// Optional perf counters (lat_last_o, busy_cycles_o) when IDMA_TRACKER_PERF_EN is defined.
module idma_xfer_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_W            = 8,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic                              direction_i,
  input  logic                              done_i,
  input  logic                              error_i,
  output logic                              issue_ready_o,
  output logic [ID_W-1:0]                   id_o,
  output logic                              id_valid_o,
  input  logic                              wait_req_i,
  input  logic [ID_W-1:0]                   wait_id_i,
  output logic                              wait_gnt_o,
  output logic [1:0]                        evt_o,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              err_o,
  output logic [ID_W-1:0]                   err_id_o,
  output logic                              overflow_o
`ifdef IDMA_TRACKER_PERF_EN
  ,
  output logic [CNT_W-1:0]                  lat_last_o,
  output logic [CNT_W-1:0]                  busy_cycles_o
`endif
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  if ((MAX_OUTSTANDING < 2) || ((1 << PtrW) != MAX_OUTSTANDING)) begin : g_chk_depth
    $error("MAX_OUTSTANDING must be a power of two >= 2");
  end
  if ((2 ** ID_W) <= (2 * MAX_OUTSTANDING)) begin : g_chk_id
    $error("ID_W too narrow for MAX_OUTSTANDING");
  end
  if (CNT_W < 1) begin : g_chk_cnt
    $error("CNT_W must be >= 1");
  end

  logic [ID_W-1:0]            id_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]            id_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] dir_q, dir_d;
  logic [MAX_OUTSTANDING-1:0] vld_q, vld_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [ID_W-1:0]            next_id_q, next_id_d;
  logic [ID_W-1:0]            id_out_q, id_out_d;
  logic                       id_valid_q, id_valid_d;
  logic [1:0]                 evt_q, evt_d;
  logic                       err_q, err_d;
  logic [ID_W-1:0]            err_id_q, err_id_d;
  logic                       ovf_q, ovf_d;

  logic full, push, pop, hit;

`ifdef IDMA_TRACKER_PERF_EN
  logic [CNT_W-1:0] ts_q [MAX_OUTSTANDING];
  logic [CNT_W-1:0] ts_d [MAX_OUTSTANDING];
  logic [CNT_W-1:0] cyc_q, cyc_d, lat_q, lat_d, busy_q, busy_d;
`endif

  // Full is judged on registered state only, so a same-cycle pop cannot admit a start.
  assign full = (cnt_q == CntW'(MAX_OUTSTANDING));
  assign push = start_i && !full;
  assign pop  = (done_i || error_i) && (cnt_q != '0);

  always_comb begin
    id_d       = id_q;
    dir_d      = dir_q;
    vld_d      = vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    next_id_d  = next_id_q;
    id_out_d   = id_out_q;
    id_valid_d = 1'b0;
    evt_d      = 2'b00;
    err_d      = err_q;
    err_id_d   = err_id_q;
    ovf_d      = ovf_q;

    if (pop) begin
      vld_d[rd_ptr_q]       = 1'b0;
      rd_ptr_d              = rd_ptr_q + PtrW'(1);
      evt_d[dir_q[rd_ptr_q]] = 1'b1;
      if (error_i) begin
        err_d = 1'b1;
        if (!err_q) err_id_d = id_q[rd_ptr_q];
      end
    end

    if (push) begin
      id_d[wr_ptr_q]  = next_id_q;
      dir_d[wr_ptr_q] = direction_i;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
      next_id_d       = next_id_q + ID_W'(1);
      id_out_d        = next_id_q;
      id_valid_d      = 1'b1;
    end else if (start_i) begin
      ovf_d = 1'b1;
      err_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef IDMA_TRACKER_PERF_EN
  // Latency is the modular timestamp difference; exact for transfers shorter than 2**CNT_W cycles.
  always_comb begin
    ts_d   = ts_q;
    cyc_d  = cyc_q + CNT_W'(1);
    lat_d  = lat_q;
    busy_d = busy_q;
    if (push) ts_d[wr_ptr_q] = cyc_q;
    if (pop) lat_d = cyc_q - ts_q[rd_ptr_q];
    if ((cnt_q != '0) && (busy_q != '1)) busy_d = busy_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ts_q   <= '{default: '0};
      cyc_q  <= '0;
      lat_q  <= '0;
      busy_q <= '0;
    end else begin
      ts_q   <= ts_d;
      cyc_q  <= cyc_d;
      lat_q  <= lat_d;
      busy_q <= busy_d;
    end
  end

  assign lat_last_o    = lat_q;
  assign busy_cycles_o = busy_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      id_q       <= '{default: '0};
      dir_q      <= '0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      next_id_q  <= '0;
      id_out_q   <= '0;
      id_valid_q <= 1'b0;
      evt_q      <= 2'b00;
      err_q      <= 1'b0;
      err_id_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      id_q       <= id_d;
      dir_q      <= dir_d;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      next_id_q  <= next_id_d;
      id_out_q   <= id_out_d;
      id_valid_q <= id_valid_d;
      evt_q      <= evt_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (vld_q[i] && (id_q[i] == wait_id_i)) hit = 1'b1;
    end
  end

  assign wait_gnt_o    = wait_req_i && !hit;
  assign issue_ready_o = !full;
  assign id_o          = id_out_q;
  assign id_valid_o    = id_valid_q;
  assign evt_o         = evt_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;
  assign err_id_o      = err_id_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_idma_xfer_tracker.sv
// Randomized bench for idma_xfer_tracker against a queue-based transfer model.
module tb_idma_xfer_tracker;
  localparam int MAX = 4;
  localparam int IDW = 8;

  logic           clk = 1'b0;
  logic           rst_i, clear_i, start_i, direction_i, done_i, error_i;
  logic           issue_ready_o, id_valid_o, wait_req_i, wait_gnt_o;
  logic           err_o, overflow_o;
  logic [IDW-1:0] id_o, wait_id_i, err_id_o;
  logic [1:0]     evt_o;
  logic [2:0]     outstanding_o;

  always #5 clk = ~clk;

  idma_xfer_tracker #(
    .MAX_OUTSTANDING(MAX),
    .ID_W           (IDW),
    .CNT_W          (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .direction_i  (direction_i),
    .done_i       (done_i),
    .error_i      (error_i),
    .issue_ready_o(issue_ready_o),
    .id_o         (id_o),
    .id_valid_o   (id_valid_o),
    .wait_req_i   (wait_req_i),
    .wait_id_i    (wait_id_i),
    .wait_gnt_o   (wait_gnt_o),
    .evt_o        (evt_o),
    .outstanding_o(outstanding_o),
    .err_o        (err_o),
    .err_id_o     (err_id_o),
    .overflow_o   (overflow_o)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           dir;
  } ent_t;

  ent_t           mq[$];
  logic [IDW-1:0] m_next_id, m_id, m_err_id;
  logic           m_idv, m_err, m_ovf;
  logic [1:0]     m_evt;
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_next_id = '0;
    m_id      = '0;
    m_err_id  = '0;
    m_idv     = 1'b0;
    m_err     = 1'b0;
    m_ovf     = 1'b0;
    m_evt     = 2'b00;
  endfunction

  function automatic void model_clock(bit s, bit dir, bit dn, bit er, bit clr);
    bit   was_full, old_err;
    ent_t h;
    if (clr) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == MAX);
    old_err  = m_err;
    m_evt    = 2'b00;
    m_idv    = 1'b0;
    if ((dn || er) && mq.size() > 0) begin
      h = mq.pop_front();
      m_evt[h.dir] = 1'b1;
      if (er) begin
        if (!old_err) m_err_id = h.id;
        m_err = 1'b1;
      end
    end
    if (s) begin
      if (was_full) begin
        m_ovf = 1'b1;
        m_err = 1'b1;
      end else begin
        mq.push_back('{id: m_next_id, dir: dir});
        m_id      = m_next_id;
        m_idv     = 1'b1;
        m_next_id = m_next_id + 1'b1;
      end
    end
  endfunction

  task automatic check_regs();
    check_eq("id_o", id_o, m_id);
    check_eq("id_valid_o", id_valid_o, m_idv);
    check_eq("evt_o", evt_o, m_evt);
    check_eq("outstanding_o", outstanding_o, mq.size());
    check_eq("issue_ready_o", issue_ready_o, mq.size() != MAX);
    check_eq("err_o", err_o, m_err);
    check_eq("err_id_o", err_id_o, m_err_id);
    check_eq("overflow_o", overflow_o, m_ovf);
  endtask

  // Called just after a falling edge; applies inputs for one rising edge.
  task automatic step(input bit s, input bit dir, input bit dn, input bit er, input bit wr,
                      input logic [IDW-1:0] wid, input bit clr);
    bit hit;
    start_i     = s;
    direction_i = dir;
    done_i      = dn;
    error_i     = er;
    wait_req_i  = wr;
    wait_id_i   = wid;
    clear_i     = clr;
    #1;
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].id == wid) hit = 1'b1;
    check_eq("wait_gnt_o", wait_gnt_o, wr && !hit);
    @(posedge clk);
    model_clock(s, dir, dn, er, clr);
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; direction_i = 1'b0;
    done_i = 1'b0; error_i = 1'b0; wait_req_i = 1'b0; wait_id_i = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("rst_issue_ready", issue_ready_o, 1);
    check_regs();

    // Single transfer round trip
    step(1, 0, 0, 0, 0, 8'd0, 0);
    check_eq("first_id", id_o, 0);
    check_eq("first_id_valid", id_valid_o, 1);
    step(0, 0, 1, 0, 0, 8'd0, 0);
    check_eq("first_evt", evt_o, 2'b01);

    // Overfill
    step(0, 0, 0, 0, 0, 8'd0, 1);
    for (int i = 0; i < 5; i++) step(1, i[0], 0, 0, 0, 8'd0, 0);
    check_eq("ovf_flag", overflow_o, 1);
    check_eq("ovf_ready", issue_ready_o, 0);
    check_eq("ovf_last_id", id_o, 3);

    // Start and done together with two in flight
    step(0, 0, 0, 0, 0, 8'd0, 1);
    step(1, 1, 0, 0, 0, 8'd0, 0);
    step(1, 0, 0, 0, 0, 8'd0, 0);
    step(1, 0, 1, 0, 0, 8'd0, 0);
    check_eq("simul_outstanding", outstanding_o, 2);
    check_eq("simul_evt", evt_o, 2'b10);

    // Wait queries
    step(0, 0, 0, 0, 0, 8'd0, 1);
    step(1, 0, 0, 0, 1, 8'd1, 0);
    step(1, 1, 0, 0, 1, 8'd1, 0);
    step(0, 0, 1, 0, 1, 8'd1, 0);
    step(0, 0, 1, 0, 1, 8'd1, 0);
    step(0, 0, 0, 0, 1, 8'd1, 0);
    step(0, 0, 0, 0, 1, 8'd7, 0);

    // First error id retained
    step(0, 0, 0, 0, 0, 8'd0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 8'd0, 0);
    step(0, 0, 1, 0, 0, 8'd0, 0);
    step(1, 1, 0, 0, 0, 8'd0, 0);
    step(1, 0, 0, 1, 0, 8'd0, 0);
    step(0, 0, 0, 1, 0, 8'd0, 0);
    check_eq("first_err_id", err_id_o, 3);

    // ID wrap: one in flight, start and done every cycle
    for (int i = 0; i < 300; i++) step(1, 1'($urandom), 1, 0, 1, m_next_id - 8'd1, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0), 1'($urandom),
           m_next_id - 8'($urandom_range(0, 6)), ($urandom_range(0, 499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
